// File: rtl/i2c_target_if.sv
// rtl/i2c_target_if.sv - I2C target front end: START/STOP detect, address match, byte rx/tx
module i2c_target_if #(
    parameter logic [6:0] DEV_ADDR    = 7'h2A,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_first,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       stop_p,
    output logic       busy
);

    typedef enum logic [2:0] {IDLE, ADDR, A_ACK, WR, W_ACK, RD, M_ACK} state_t;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_prev, sda_prev;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_det, stop_det;

    state_t     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic       rw_q, rw_d;
    logic       first_q, first_d;
    logic       sda_oe_q, sda_oe_d;
    logic       busy_q, busy_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_d, rx_first_d, tx_req_d, stop_p_d;

    // Synchroniser and history flops; reset to the idle-bus level so reset release cannot fake an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_prev <= scl_sync[SYNC_STAGES-1];
            sda_prev <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  =  scl_s & ~scl_prev;
    assign scl_fall  = ~scl_s &  scl_prev;
    assign start_det = ~sda_s &  sda_prev & scl_s;
    assign stop_det  =  sda_s & ~sda_prev & scl_s;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= 8'h00;
            bit_cnt_q <= 4'd0;
            rw_q      <= 1'b0;
            first_q   <= 1'b0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            rx_data_q <= 8'h00;
            rx_valid  <= 1'b0;
            rx_first  <= 1'b0;
            tx_req    <= 1'b0;
            stop_p    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            rw_q      <= rw_d;
            first_q   <= first_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
            rx_data_q <= rx_data_d;
            rx_valid  <= rx_valid_d;
            rx_first  <= rx_first_d;
            tx_req    <= tx_req_d;
            stop_p    <= stop_p_d;
        end
    end

    // Next-state logic: bus conditions first, then per-state bit handling on SCL edges
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        rw_d       = rw_q;
        first_d    = first_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_first_d = 1'b0;
        tx_req_d   = 1'b0;
        stop_p_d   = 1'b0;
        if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
        end else if (stop_det) begin
            state_d  = IDLE;
            stop_p_d = 1'b1;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                ADDR, WR: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        if (state_q == WR) begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                            rx_first_d = first_q;
                            first_d    = 1'b0;
                            sda_oe_d   = 1'b1;
                            state_d    = W_ACK;
                        end else if (shift_q[7:1] == DEV_ADDR) begin
                            rw_d     = shift_q[0];
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                            state_d  = A_ACK;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end
                    end
                end
                A_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = 4'd0;
                        if (rw_q) begin
                            tx_req_d = 1'b1;
                            shift_d  = tx_data;
                            sda_oe_d = ~tx_data[7];
                            state_d  = RD;
                        end else begin
                            first_d  = 1'b1;
                            sda_oe_d = 1'b0;
                            state_d  = WR;
                        end
                    end
                end
                W_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                        state_d   = WR;
                    end
                end
                RD: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        sda_oe_d = 1'b0;
                        state_d  = M_ACK;
                    end else if (scl_fall && bit_cnt_q != 4'd0) begin
                        shift_d  = {shift_q[6:0], 1'b0};
                        sda_oe_d = ~shift_q[6];
                    end
                end
                M_ACK: begin
                    // A NACK ends the read at once; an ACK refills on the following fall
                    if (scl_rise && sda_s) begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else if (scl_fall) begin
                        tx_req_d  = 1'b1;
                        shift_d   = tx_data;
                        sda_oe_d  = ~tx_data[7];
                        bit_cnt_d = 4'd0;
                        state_d   = RD;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign sda_oe  = sda_oe_q;
    assign busy    = busy_q;
    assign rx_data = rx_data_q;

endmodule
